// File: rtl/wb_trace_checker.sv
// Run controller and writeback checker for the 5-stage pipeline: sequences its reset and compares retired
// register writes against an expected-trace FIFO. Define WB_TRACE_STALL_STAT_EN to enable the stall/flush counter.
module wb_trace_checker #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int DEPTH      = 16,
   parameter int RST_CYCLES = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_exp_valid,
   output logic              o_exp_ready,
   input  logic [ADDR_W-1:0] i_exp_wra,
   input  logic [DATA_W-1:0] i_exp_wrd,
   input  logic              i_wb_regWe,
   input  logic [ADDR_W-1:0] i_wb_WRA,
   input  logic [DATA_W-1:0] i_wb_rstW,
   input  logic              i_pause,
   input  logic              i_clr,
   output logic              o_cpu_rstn,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_pass,
   output logic [15:0]       o_match_cnt,
   output logic [31:0]       o_cycle_cnt,
   output logic [ADDR_W-1:0] o_err_wra,
   output logic [DATA_W-1:0] o_err_got,
   output logic [DATA_W-1:0] o_err_exp,
   output logic [31:0]       o_stall_cnt
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [2:0] {IDLE, RESET, RUN, PASS, FAIL} state_t;

   state_t state, stateNext;

   logic [ADDR_W-1:0] expWra [DEPTH];
   logic [DATA_W-1:0] expWrd [DEPTH];
   logic [PTR_W:0]    wrPtr, rdPtr, wrPtrNext, rdPtrNext;
   logic [31:0]       rstCnt, wdog;

   logic              full, empty, fullNext;
   logic              wbEvent, headHit, push, pop, flush, startIdle, mismatch;
   logic [ADDR_W-1:0] headWra;
   logic [DATA_W-1:0] headWrd;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign full    = (wrPtr[PTR_W] != rdPtr[PTR_W]) && (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
   assign empty   = (wrPtr == rdPtr);
   assign headWra = expWra[rdPtr[PTR_W-1:0]];
   assign headWrd = expWrd[rdPtr[PTR_W-1:0]];

   assign wbEvent   = i_wb_regWe && (i_wb_WRA != '0);
   assign headHit   = !empty && (i_wb_WRA == headWra) && (i_wb_rstW == headWrd);
   assign push      = (state == IDLE) && i_exp_valid && !full;
   assign pop       = (state == RUN) && wbEvent && headHit;
   assign mismatch  = (state == RUN) && wbEvent && !headHit;
   assign flush     = ((state == PASS) || (state == FAIL)) && i_start;
   assign startIdle = (state == IDLE) && i_start;

   always_comb begin
      wrPtrNext = flush ? '0 : wrPtr + {{PTR_W{1'b0}}, push};
      rdPtrNext = flush ? '0 : rdPtr + {{PTR_W{1'b0}}, pop};
      fullNext  = (wrPtrNext[PTR_W] != rdPtrNext[PTR_W]) &&
                  (wrPtrNext[PTR_W-1:0] == rdPtrNext[PTR_W-1:0]);
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:  if (i_start) stateNext = RESET;
         RESET: if (rstCnt == 32'(RST_CYCLES - 1)) stateNext = RUN;
         RUN: begin
            // A match clears the watchdog, so it beats a same-cycle timeout.
            if (wbEvent) begin
               if (!headHit) stateNext = FAIL;
            end else if (empty) begin
               stateNext = PASS;
            end else if (wdog + 32'd1 == 32'(TIMEOUT)) begin
               stateNext = FAIL;
            end
         end
         PASS, FAIL: if (i_start) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         expWra[wrPtr[PTR_W-1:0]] <= i_exp_wra;
         expWrd[wrPtr[PTR_W-1:0]] <= i_exp_wrd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         wrPtr       <= '0;
         rdPtr       <= '0;
         rstCnt      <= '0;
         wdog        <= '0;
         o_exp_ready <= 1'b1;
         o_cpu_rstn  <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_pass      <= 1'b0;
         o_match_cnt <= '0;
         o_cycle_cnt <= '0;
         o_err_wra   <= '0;
         o_err_got   <= '0;
         o_err_exp   <= '0;
      end else begin
         state       <= stateNext;
         wrPtr       <= wrPtrNext;
         rdPtr       <= rdPtrNext;
         o_exp_ready <= (stateNext == IDLE) && !fullNext;
         o_cpu_rstn  <= (stateNext == RUN);
         o_busy      <= (stateNext == RESET) || (stateNext == RUN);
         o_done      <= (stateNext == PASS) || (stateNext == FAIL);
         o_pass      <= (stateNext == PASS);

         rstCnt <= (state == RESET) ? rstCnt + 32'd1 : '0;
         wdog   <= ((state == RUN) && !pop) ? wdog + 32'd1 : '0;

         if (startIdle) begin
            o_match_cnt <= '0;
            o_cycle_cnt <= '0;
            o_err_wra   <= '0;
            o_err_got   <= '0;
            o_err_exp   <= '0;
         end else if (state == RUN) begin
            if (o_cycle_cnt != '1) o_cycle_cnt <= o_cycle_cnt + 32'd1;
            if (pop && (o_match_cnt != '1)) o_match_cnt <= o_match_cnt + 16'd1;
            if (mismatch) begin
               o_err_wra <= i_wb_WRA;
               o_err_got <= i_wb_rstW;
               o_err_exp <= empty ? '0 : headWrd;
            end
         end
      end
   end

`ifdef WB_TRACE_STALL_STAT_EN
   logic [31:0] stallCnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stallCnt <= '0;
      end else if (startIdle) begin
         stallCnt <= '0;
      end else if ((state == RUN) && (i_pause || i_clr) && (stallCnt != '1)) begin
         stallCnt <= stallCnt + 32'd1;
      end
   end

   assign o_stall_cnt = stallCnt;
`else
   logic unusedStallIn;
   assign unusedStallIn = i_pause ^ i_clr;
   assign o_stall_cnt   = '0;
`endif

endmodule

// File: doc/wb_trace_checker.md
# wb_trace_checker

Parametrised run controller and writeback checker for the 5-stage pipeline (fetch/decode/execute/memory/writeback).
- Sequences the pipeline's active-low reset.
- Compares every retired register write against an expected trace held in an internal FIFO.
- Reports pass/fail, with a watchdog timeout and first-mismatch capture.
- Sits beside the pipeline in simulation and FPGA bring-up, replacing free-running clock/reset stimulus with a self-checking harness.

## Interface
Parameters:
- DATA_W, 32, writeback data width
- ADDR_W, 5, register address width
- DEPTH, 16, expected-trace FIFO entries (power of two, ≥2)
- RST_CYCLES, 4, cycles `o_cpu_rstn` is held low after start (≥1)
- TIMEOUT, 1024, max cycles between accepted writebacks in RUN (≥1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle start/acknowledge pulse
- i_exp_valid  in  1  expected-entry push request
- o_exp_ready  out  1  push accepted this cycle when high with valid
- i_exp_wra  in  ADDR_W  expected destination register
- i_exp_wrd  in  DATA_W  expected write data
- i_wb_regWe  in  1  pipeline writeback enable
- i_wb_WRA  in  ADDR_W  pipeline writeback address
- i_wb_rstW  in  DATA_W  pipeline writeback data
- i_pause  in  1  decode-stage stall indicator
- i_clr  in  1  execute-stage flush indicator
- o_cpu_rstn  out  1  active-low reset to all pipeline stages
- o_busy  out  1  state is RESET or RUN
- o_done  out  1  state is PASS or FAIL
- o_pass  out  1  state is PASS
- o_match_cnt  out  16  accepted matching writebacks
- o_cycle_cnt  out  32  cycles spent in RUN
- o_err_wra  out  ADDR_W  address observed at first failure
- o_err_got  out  DATA_W  data observed at first failure
- o_err_exp  out  DATA_W  FIFO head data at first failure
- o_stall_cnt  out  32  stall/flush cycles (only with WB_TRACE_STALL_STAT_EN)

## Operation
- States: IDLE, RESET, RUN, PASS, FAIL. Reset state is IDLE.
- IDLE:
  - `o_cpu_rstn`=0. `o_exp_ready` = FIFO not full; all other states drive it 0.
  - `i_start` → RESET; clears `o_match_cnt`, `o_cycle_cnt`, `o_stall_cnt`, `o_err_*`.
- RESET: `o_cpu_rstn`=0 for exactly RST_CYCLES cycles, then → RUN.
- RUN:
  - `o_cpu_rstn`=1; cycle counter increments every cycle.
  - A writeback event is `i_wb_regWe`=1 and `i_wb_WRA`≠0. Writes to register 0 are ignored entirely.
  - Event with FIFO non-empty, address and data equal to the head → pop, `o_match_cnt`+1, watchdog cleared.
  - Event with FIFO non-empty and any mismatch → FAIL; capture observed WRA/data and head data.
  - Event with FIFO empty → FAIL; capture observed values, `o_err_exp`=0.
  - FIFO empty with no event in the same cycle → PASS.
  - Watchdog reaches TIMEOUT → FAIL; `o_err_*` = 0. A match in the same cycle takes priority.
- PASS/FAIL:
  - Sticky; `o_cpu_rstn`=0.
  - `i_start` → IDLE and flushes the FIFO. Counters are held until the next start from IDLE.
- `i_start` is ignored in RESET and RUN. Pushes are ignored outside IDLE.
- Counters saturate at all-ones; no wrap.
- Asynchronous `rst` at any point: state IDLE, FIFO empty, all counters and `o_err_*` 0, `o_cpu_rstn`=0.

## Timing
- All outputs are registered.
- Reset values: `o_cpu_rstn`=0, `o_busy`=0, `o_done`=0, `o_pass`=0, `o_exp_ready`=1, all counts and `o_err_*` = 0.
- `i_start` in IDLE at edge N: `o_busy`=1 after N. `o_cpu_rstn` rises after edge N+RST_CYCLES; the first RUN cycle follows.
- Compare latency: an event sampled at edge K updates the FIFO head, `o_match_cnt` and state after edge K. `o_done` is visible in the following cycle.
- FIFO full: `o_exp_ready`=0 in the same cycle the DEPTH-th entry is accepted. A push at full is dropped.
- Watchdog:
  - Counts RUN cycles without a match.
  - FAIL is entered at the edge where the count equals TIMEOUT.
  - Count is reset on RUN entry.

## Configuration
- WB_TRACE_STALL_STAT_EN defined:
  - `o_stall_cnt` increments once per RUN cycle where `i_pause` | `i_clr` is high.
  - A cycle with both high counts once.
  - Saturates; cleared by start from IDLE and by `rst`.
- Not defined: `o_stall_cnt` is tied to 0 and `i_pause`/`i_clr` are unused.

## Test plan
- Push (3,0x11),(4,0x22); start; drive `regWe` with WRA=3/0x11 then WRA=4/0x22 → PASS, `o_match_cnt`=2. `o_cpu_rstn` low for exactly 4 cycles after start.
- Push (3,0x11); observe WRA=3/0x12 → FAIL; `o_err_wra`=3, `o_err_got`=0x12, `o_err_exp`=0x11.
- Push (5,0x1); observe WRA=0/0xFF, then WRA=5/0x1 → PASS. The register-0 write does not pop the FIFO.
- Push 16 entries with DEPTH=16 → `o_exp_ready`=0. A 17th push is dropped; 16 matches → `o_match_cnt`=16, PASS.
- TIMEOUT=8, one entry, no writebacks → FAIL after exactly 8 RUN cycles, `o_err_*`=0. Assert `rst` in RUN → IDLE with outputs at reset values.
- With WB_TRACE_STALL_STAT_EN: `i_pause` for 3 RUN cycles, `i_clr` for 2 (1 overlapping) → `o_stall_cnt`=4.
